// File: rtl/ram_slot_arbiter_pkg.sv
// Shared types for the SRAM slot arbiter: slot owner encoding and the
// priority rule applied at each slot boundary.
package ram_slot_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_VIDEO = 2'd1,
    OWNER_CPU   = 2'd2,
    OWNER_DMA   = 2'd3
  } owner_t;

  localparam logic [1:0] PHASE_LAST = 2'd3;

  // Video always wins; a CPU/DMA contest is settled by the round-robin bit.
  function automatic owner_t pick_owner(input logic video, input logic cpu,
                                        input logic dma, input logic rr_dma);
    if (video)
      return OWNER_VIDEO;
    if (cpu && dma)
      return rr_dma ? OWNER_DMA : OWNER_CPU;
    if (cpu)
      return OWNER_CPU;
    if (dma)
      return OWNER_DMA;
    return OWNER_NONE;
  endfunction

endpackage

// File: rtl/ram_slot_arbiter_slot_phase.sv
// Four-phase slot counter locked to ck7; outputs one-hot decodes of the
// phase being entered at the next clk28 edge.
module slot_phase
  import ram_slot_arbiter_pkg::*;
(
  input  logic clk28,
  input  logic rst_n,
  input  logic ck7,
  output logic into_p0,
  output logic into_p1,
  output logic into_p2,
  output logic into_p3
);

  logic [1:0] phase;
  logic [1:0] phase_next;

  always_comb begin
    phase_next = '0;
    if (!ck7 && phase != PHASE_LAST)
      phase_next = phase + 2'd1;
  end

  always_ff @(posedge clk28) begin
    if (!rst_n)
      phase <= '0;
    else
      phase <= phase_next;
  end

  assign into_p0 = (phase_next == 2'd0);
  assign into_p1 = (phase_next == 2'd1);
  assign into_p2 = (phase_next == 2'd2);
  assign into_p3 = (phase_next == 2'd3);

endmodule

// File: rtl/ram_slot_arbiter.sv
// Time-slices one 512Kx8 SRAM between video, CPU and DMA in 4-clk28 slots;
// video has absolute priority, CPU and DMA alternate when both are waiting.
module ram_slot_arbiter
  import ram_slot_arbiter_pkg::*;
#(
  parameter int unsigned AW = 19,
  parameter int unsigned DW = 8
) (
  input  logic          clk28,
  input  logic          rst_n,
  input  logic          ck7,
  input  logic          video_req,
  input  logic [AW-1:0] video_addr,
  output logic          video_valid,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_hold,
  output logic          cpu_done,
  input  logic          dma_req,
  input  logic          dma_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_dout,
  output logic          ram_dout_en,
  output logic          ram_oe_n,
  output logic          ram_we_n,
  input  logic [DW-1:0] ram_din,
  output logic [DW-1:0] rd_data,
  output logic [1:0]    owner
);

  logic          into_p0, into_p1, into_p2, into_p3;
  owner_t        owner_q, grant;
  logic          rr_dma, cpu_served, slot_wr, cpu_pending;
  logic [AW-1:0] grant_addr;
  logic [DW-1:0] grant_wdata;
  logic          grant_wr;

  slot_phase u_slot_phase (
    .clk28   (clk28),
    .rst_n   (rst_n),
    .ck7     (ck7),
    .into_p0 (into_p0),
    .into_p1 (into_p1),
    .into_p2 (into_p2),
    .into_p3 (into_p3)
  );

  assign cpu_pending = cpu_req && !cpu_served;
  assign cpu_hold    = cpu_pending;
  assign owner       = owner_q;
  assign grant       = pick_owner(video_req, cpu_pending, dma_req, rr_dma);

  always_comb begin
    grant_addr  = video_addr;
    grant_wdata = '0;
    grant_wr    = 1'b0;
    case (grant)
      OWNER_CPU: begin
        grant_addr  = cpu_addr;
        grant_wdata = cpu_wdata;
        grant_wr    = cpu_wr;
      end
      OWNER_DMA: begin
        grant_addr  = dma_addr;
        grant_wdata = dma_wdata;
        grant_wr    = dma_wr;
      end
      default: ;
    endcase
  end

  // Every entry into phase 0 (natural wrap or ck7 resync) starts a fresh slot,
  // so a truncated slot simply has its strobes overwritten here.
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      owner_q     <= OWNER_NONE;
      rr_dma      <= 1'b0;
      cpu_served  <= 1'b0;
      slot_wr     <= 1'b0;
      ram_a       <= '0;
      ram_dout    <= '0;
      ram_dout_en <= 1'b0;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      rd_data     <= '0;
      video_valid <= 1'b0;
      cpu_done    <= 1'b0;
      dma_ack     <= 1'b0;
    end else begin
      video_valid <= 1'b0;
      cpu_done    <= 1'b0;
      dma_ack     <= 1'b0;

      if (!cpu_req)
        cpu_served <= 1'b0;
      else if (into_p3 && owner_q == OWNER_CPU)
        cpu_served <= 1'b1;

      if (into_p0) begin
        owner_q  <= grant;
        slot_wr  <= grant_wr;
        ram_we_n <= 1'b1;
        if (grant == OWNER_NONE) begin
          ram_oe_n    <= 1'b1;
          ram_dout_en <= 1'b0;
        end else begin
          ram_a       <= grant_addr;
          ram_oe_n    <= grant_wr;
          ram_dout_en <= grant_wr;
          if (grant_wr)
            ram_dout <= grant_wdata;
        end
        if (!video_req && cpu_pending && dma_req)
          rr_dma <= ~rr_dma;
      end

      if (into_p1 && slot_wr)
        ram_we_n <= 1'b0;

      if (into_p2)
        ram_we_n <= 1'b1;

      if (into_p3 && owner_q != OWNER_NONE) begin
        if (!slot_wr)
          rd_data <= ram_din;
        ram_oe_n    <= 1'b1;
        ram_dout_en <= 1'b0;
        video_valid <= (owner_q == OWNER_VIDEO);
        cpu_done    <= (owner_q == OWNER_CPU);
        dma_ack     <= (owner_q == OWNER_DMA);
      end
    end
  end

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Directed scenarios plus randomized traffic against a slot-level model of
// the arbiter; every cycle's outputs are compared with the model.
module tb_ram_slot_arbiter;
  import ram_slot_arbiter_pkg::*;

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 8;

  logic          clk28 = 1'b0;
  logic          rst_n, ck7, video_req, video_valid, cpu_req, cpu_wr, cpu_hold, cpu_done;
  logic          dma_req, dma_wr, dma_ack, ram_dout_en, ram_oe_n, ram_we_n;
  logic [AW-1:0] video_addr, cpu_addr, dma_addr, ram_a;
  logic [DW-1:0] cpu_wdata, dma_wdata, ram_dout, ram_din, rd_data;
  logic [1:0]    owner;

  int total = 0;
  int bad   = 0;

  // Slot-level reference state
  int            m_ph;
  owner_t        m_owner;
  logic          m_wr, m_served, m_rr, m_vv, m_cd, m_da;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_dout, m_rd;
  logic          auto_ck7 = 1'b1;

  always #5 clk28 = ~clk28;

  ram_slot_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk28(clk28), .rst_n(rst_n), .ck7(ck7),
    .video_req(video_req), .video_addr(video_addr), .video_valid(video_valid),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_hold(cpu_hold), .cpu_done(cpu_done),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_dout_en(ram_dout_en),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_din(ram_din),
    .rd_data(rd_data), .owner(owner)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model across one clk28 edge using the inputs held before it.
  task automatic model_edge();
    int   nph;
    logic pend;
    if (!rst_n) begin
      m_ph = 0; m_owner = OWNER_NONE; m_wr = 1'b0; m_a = '0; m_rd = '0;
      m_served = 1'b0; m_rr = 1'b0; m_vv = 1'b0; m_cd = 1'b0; m_da = 1'b0;
      return;
    end
    nph  = ck7 ? 0 : (m_ph + 1) % 4;
    pend = cpu_req && !m_served;
    m_vv = (nph == 3) && (m_owner == OWNER_VIDEO);
    m_cd = (nph == 3) && (m_owner == OWNER_CPU);
    m_da = (nph == 3) && (m_owner == OWNER_DMA);
    if (nph == 3 && m_owner != OWNER_NONE && !m_wr)
      m_rd = ram_din;
    if (!cpu_req)
      m_served = 1'b0;
    else if (nph == 3 && m_owner == OWNER_CPU)
      m_served = 1'b1;
    if (nph == 0) begin
      if (video_req)
        m_owner = OWNER_VIDEO;
      else if (pend && dma_req) begin
        m_owner = m_rr ? OWNER_DMA : OWNER_CPU;
        m_rr = !m_rr;
      end else if (pend)
        m_owner = OWNER_CPU;
      else if (dma_req)
        m_owner = OWNER_DMA;
      else
        m_owner = OWNER_NONE;
      m_wr = 1'b0;
      if (m_owner == OWNER_VIDEO) m_a = video_addr;
      if (m_owner == OWNER_CPU) begin
        m_a = cpu_addr; m_wr = cpu_wr;
        if (cpu_wr) m_dout = cpu_wdata;
      end
      if (m_owner == OWNER_DMA) begin
        m_a = dma_addr; m_wr = dma_wr;
        if (dma_wr) m_dout = dma_wdata;
      end
    end
    m_ph = nph;
  endtask

  // Strobes follow directly from who owns the slot and where in it we are.
  task automatic check_all();
    logic act;
    act = (m_owner != OWNER_NONE);
    check("owner", owner, m_owner);
    check("ram_a", ram_a, m_a);
    check("oe_n", ram_oe_n, !(act && !m_wr && m_ph != 3));
    check("we_n", ram_we_n, !(act && m_wr && m_ph == 1));
    check("dout_en", ram_dout_en, act && m_wr && m_ph != 3);
    if (act && m_wr && m_ph != 3)
      check("ram_dout", ram_dout, m_dout);
    check("rd_data", rd_data, m_rd);
    check("video_valid", video_valid, m_vv);
    check("cpu_done", cpu_done, m_cd);
    check("dma_ack", dma_ack, m_da);
    check("cpu_hold", cpu_hold, cpu_req && !m_served);
  endtask

  task automatic step();
    @(posedge clk28);
    model_edge();
    #1;
    check_all();
    if (auto_ck7)
      ck7 = (m_ph == 3);
  endtask

  task automatic goto_phase(input int p);
    for (int i = 0; i < 8 && m_ph != p; i++)
      step();
    check("goto_phase", m_ph, p);
  endtask

  owner_t c_exp [6] = '{OWNER_CPU, OWNER_DMA, OWNER_CPU, OWNER_DMA, OWNER_DMA, OWNER_CPU};
  logic   c_cpu [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic   c_dma [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int hcnt, acks, ndone, nack, nvalid;
    ck7 = 1'b0; video_req = 1'b0; video_addr = '0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_wr = 1'b0; dma_addr = '0; dma_wdata = '0;
    ram_din = '0; m_dout = '0;

    // Reset with a CPU request pending
    rst_n = 1'b0; cpu_req = 1'b1;
    repeat (3) step();
    check("rst_oe_n", ram_oe_n, 1'b1);
    check("rst_we_n", ram_we_n, 1'b1);
    check("rst_dout_en", ram_dout_en, 1'b0);
    check("rst_owner", owner, OWNER_NONE);
    check("rst_hold", cpu_hold, 1'b1);
    cpu_req = 1'b0; rst_n = 1'b1;

    // Video-only read
    ram_din = 8'hA5;
    goto_phase(3);
    video_req = 1'b1; video_addr = 19'h04000;
    step();
    check("vid_a", ram_a, 19'h04000);
    check("vid_oe_p0", ram_oe_n, 1'b0);
    video_req = 1'b0;
    step(); check("vid_oe_p1", ram_oe_n, 1'b0);
    step(); check("vid_oe_p2", ram_oe_n, 1'b0);
    step();
    check("vid_rd", rd_data, 8'hA5);
    check("vid_valid", video_valid, 1'b1);

    // Video and CPU request in the same P3: video first, CPU held 8 clocks
    ram_din = 8'h5A; video_req = 1'b1; video_addr = 19'h00100;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 19'h12345;
    #1 hcnt = cpu_hold ? 1 : 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (i == 0) video_req = 1'b0;
      if (cpu_hold) hcnt++;
      if (cpu_done) break;
    end
    check("cv_hold_cycles", hcnt, 8);
    check("cv_done", cpu_done, 1'b1);
    check("cv_owner", owner, OWNER_CPU);
    check("cv_rd", rd_data, 8'h5A);
    cpu_req = 1'b0;
    repeat (4) step();

    // CPU/DMA sharing, including a contest after one of each has been served
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 19'h00222;
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 19'h00333;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("ct_owner", owner, c_exp[k]);
      repeat (3) step();
      if (k < 4 && dma_ack) acks++;
      cpu_req = c_cpu[k];
      dma_req = c_dma[k];
    end
    check("ct_acks", acks, 2);

    // DMA write at the top address
    dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 19'h7FFFF; dma_wdata = 8'h3C;
    step();
    check("dw_a", ram_a, 19'h7FFFF);
    check("dw_en_p0", ram_dout_en, 1'b1);
    check("dw_we_p0", ram_we_n, 1'b1);
    check("dw_dout", ram_dout, 8'h3C);
    step();
    check("dw_we_p1", ram_we_n, 1'b0);
    check("dw_en_p1", ram_dout_en, 1'b1);
    step();
    check("dw_we_p2", ram_we_n, 1'b1);
    check("dw_en_p2", ram_dout_en, 1'b1);
    step();
    check("dw_ack", dma_ack, 1'b1);
    check("dw_en_p3", ram_dout_en, 1'b0);
    dma_req = 1'b0;

    // Reset lands in P1 of a CPU write
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 19'h00ABC; cpu_wdata = 8'h77;
    step();
    check("rw_owner", owner, OWNER_CPU);
    step();
    check("rw_we_p1", ram_we_n, 1'b0);
    rst_n = 1'b0;
    step();
    check("rw_we_rst", ram_we_n, 1'b1);
    check("rw_owner_rst", owner, OWNER_NONE);
    check("rw_done_rst", cpu_done, 1'b0);
    rst_n = 1'b1; cpu_req = 1'b0;

    // Randomized traffic with occasional ck7 jitter and reset pulses
    auto_ck7 = 1'b0;
    ndone = 0; nack = 0; nvalid = 0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (cpu_done) ndone++;
      if (dma_ack) nack++;
      if (video_valid) nvalid++;
      rst_n   = ($urandom_range(0, 299) != 0);
      ram_din = DW'($urandom);
      ck7     = (m_ph == 3);
      if ($urandom_range(0, 39) == 0) ck7 = ~ck7;
      if (m_ph == 3) begin
        video_req  = ($urandom_range(0, 3) == 0);
        video_addr = AW'($urandom);
      end
      if (cpu_req) begin
        if ((cpu_done || m_served) && $urandom_range(0, 1) == 0) cpu_req = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        cpu_req = 1'b1; cpu_wr = 1'($urandom_range(0, 1));
        cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
      end
      if (dma_req) begin
        if (dma_ack) begin
          if ($urandom_range(0, 1) == 0) dma_req = 1'b0;
          else begin
            dma_wr = 1'($urandom_range(0, 1));
            dma_addr = AW'($urandom); dma_wdata = DW'($urandom);
          end
        end
      end else if ($urandom_range(0, 4) == 0) begin
        dma_req = 1'b1; dma_wr = 1'($urandom_range(0, 1));
        dma_addr = AW'($urandom); dma_wdata = DW'($urandom);
      end
    end
    check("rand_cpu_seen", ndone > 0, 1'b1);
    check("rand_dma_seen", nack > 0, 1'b1);
    check("rand_video_seen", nvalid > 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
